// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: one req/gnt/rvalid transaction per load or store.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with err.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_WE,
  input  logic [2:0]  mem_MODE,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [8:0] TimeoutW = 9'(TIMEOUT);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        we_q;
  logic [2:0]  mode_q;
  logic [1:0]  lane_q;

  logic        illegal, reject, timeout_hit;
  logic [3:0]  be_n;
  logic [31:0] wdata_n, shifted, load_val;

  assign illegal = (mem_MODE[1:0] == 2'b11);

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((mem_MODE[1:0] == 2'b01) && addr[0]) ||
                      ((mem_MODE[1:0] == 2'b00) && (addr[1:0] != 2'b00));
  assign reject = illegal | misaligned;
`else
  assign reject = illegal;
`endif

  // Counter value after this edge would reach TIMEOUT.
  assign timeout_hit = ({1'b0, cnt_q} + 9'd1) >= TimeoutW;

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = wdata;
    if (mem_WE) begin
      case (mem_MODE[1:0])
        2'b10: begin
          be_n    = 4'b0001 << addr[1:0];
          wdata_n = {4{wdata[7:0]}};
        end
        2'b01: begin
          be_n    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    shifted  = dmem_rdata >> {lane_q, 3'b000};
    load_val = dmem_rdata;
    case (mode_q[1:0])
      2'b10: load_val = {{24{mode_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01: begin
        if (lane_q[1]) load_val = {{16{mode_q[2] & dmem_rdata[31]}}, dmem_rdata[31:16]};
        else           load_val = {{16{mode_q[2] & dmem_rdata[15]}}, dmem_rdata[15:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      we_q       <= 1'b0;
      mode_q     <= 3'd0;
      lane_q     <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= 32'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_wdata <= 32'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            we_q   <= mem_WE;
            mode_q <= mem_MODE;
            lane_q <= addr[1:0];
            if (reject) begin
              state_q <= StDone;
              done    <= 1'b1;
              err     <= 1'b1;
            end else begin
              state_q    <= StReq;
              cnt_q      <= 8'd0;
              busy       <= 1'b1;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_WE;
              dmem_addr  <= {addr[31:2], 2'b00};
              dmem_be    <= be_n;
              dmem_wdata <= wdata_n;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StReq: begin
          cnt_q <= cnt_q + 8'd1;
          if (dmem_gnt) begin
            state_q  <= StWait;
            dmem_req <= 1'b0;
          end else if (timeout_hit) begin
            state_q  <= StDone;
            busy     <= 1'b0;
            dmem_req <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b1;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 8'd1;
          // A response on the timeout edge still completes normally.
          if (dmem_rvalid) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            if (!we_q) rdata <= load_val;
          end else if (timeout_hit) begin
            state_q <= StDone;
            busy    <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the RV32I core, directly downstream of the control logic. It consumes the decoded `mem_WE` and `mem_MODE` fields together with the ALU-computed address and the rs2 store data. It performs one request/grant/response transaction per access on the data-memory port, then returns aligned, sign- or zero-extended load data for register writeback. While the access is in flight it asserts `busy` so the control logic holds the Execute state.

## Interface
- `TIMEOUT`, default 255: cycles allowed in REQ+WAIT before abort; range 1..255, counter 8 bits.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `start` in 1: one-cycle request from control logic (Execute, load/store opcode).
- `mem_WE` in 1: 1 = store, 0 = load.
- `mem_MODE` in 3: [1:0] size (00 word, 01 half, 10 byte, 11 illegal); [2] 1 = sign-extend load.
- `addr` in 32: byte address from ALU.
- `wdata` in 32: store data (rs2).
- `busy` out 1: access in flight (REQ or WAIT).
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; illegal size, misalignment (macro) or timeout.
- `rdata` out 32: extended load data; holds until the next load completes.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32 (bits [1:0] = 0), `dmem_be` out 4, `dmem_wdata` out 32: memory request.
- `dmem_gnt` in 1: request accepted this cycle.
- `dmem_rvalid` in 1: response/write-ack; `dmem_rdata` in 32 valid with it.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- Reset values: all outputs 0, `rdata` = 0, timeout counter = 0.
- `start` is sampled only in IDLE or DONE. It is ignored in REQ and WAIT.
- On an accepted `start`, the block latches `mem_WE`, `mem_MODE`, `addr` and `wdata`, then either:
  - goes to REQ, or
  - goes to DONE with `err`=1 and no memory traffic if size = 11 (or if misaligned with the macro defined).
- REQ: `dmem_req`=1 with stable address, enables and data. When `dmem_gnt`=1, go to WAIT; `dmem_req` drops the next cycle.
- WAIT: when `dmem_rvalid`=1, go to DONE. For a load, `rdata` is captured from `dmem_rdata` on that edge. Stores also wait for `rvalid` as the write ack.
- DONE: `done`=1 for exactly one cycle. The FSM then goes to IDLE, or straight to REQ on an accepted `start` (back-to-back accesses).
- Timeout: the counter clears on entering REQ and increments each cycle in REQ/WAIT. When it reaches `TIMEOUT` the access aborts to DONE with `err`=1 and `rdata` unchanged.
- Lane select is `a = addr[1:0]`.
- Store byte (size 10):
  - `dmem_be` = 1<<a.
  - `dmem_wdata` = wdata[7:0] replicated ×4.
- Store half (size 01):
  - `dmem_be` = 0011 if a[1]=0, else 1100.
  - `dmem_wdata` = wdata[15:0] replicated ×2.
- Store word (size 00): `dmem_be` = 1111, `dmem_wdata` = wdata.
- Loads:
  - `dmem_be` = 1111.
  - Byte: rdata[8a+7:8a], extended per mode[2].
  - Half: rdata[16a[1]+15:16a[1]], extended per mode[2].
  - Word: rdata taken unmodified; mode[2] ignored.
- `dmem_addr` = {addr[31:2], 2'b00}.
- `err` is low on successful completion.

## Timing
- Minimum latency: `start` at edge T0 → `dmem_req` high after T0 → gnt at T1 → rvalid at T2 → `done` high after T2 (3 cycles).
- Each added cycle of gnt or rvalid delay adds one cycle.
- `busy` is registered (high in REQ/WAIT) and `done` is registered.
- `dmem_gnt` and `dmem_rvalid` outside REQ/WAIT respectively are ignored. An `rvalid` coinciding with `gnt` in REQ is ignored.
- Timeout on the same edge as `rvalid`: `rvalid` wins and completion is normal.
- Asserting `reset` mid-transaction: the FSM returns to IDLE and `dmem_req`/`busy`/`done` drop immediately. An outstanding response after release is ignored.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: a half with a[0]=1, or a word with a≠00, completes as a one-cycle DONE with `err`=1 and no request.
- `LSU_MISALIGN_TRAP_EN` undefined: the same access is issued with the offending low bits ignored (half uses a[1]; word uses lane 0) and `err`=0.

## Test plan
- After reset release: all outputs are 0. Then LW at addr 0x100, gnt immediate, rvalid next cycle with 0xDEADBEEF → `rdata`=0xDEADBEEF, `done` 3 cycles after `start`.
- LB at 0x103 with memory word 0x80FF_0000 → `rdata`=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB at 0x101 with wdata 0x12345678 → `dmem_be`=0010, `dmem_wdata`=0x78787878, `dmem_addr`=0x100. SH at 0x102 → `dmem_be`=1100, `dmem_wdata`=0x56785678.
- Gnt withheld for 4 cycles → `dmem_req` holds stable for 5 cycles and `busy` stays high. With `TIMEOUT`=8 and no rvalid → `done`+`err` 8 cycles after entering REQ.
- LW at 0x102 → with the macro, `err`=1 and no `dmem_req`; without it, a request to 0x100 and `err`=0. `mem_MODE`=011 → `err`=1 in both builds.
- `reset` pulled low during WAIT → `busy`=0 immediately; a late rvalid after release leaves `rdata`=0 and `done`=0.
